// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter: pipeline writeback first, then a FIFO of late long-latency results.
// Optional same-cycle write-to-read bypass under REGFILE_WB_BYPASS_EN.
module regfile_write_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        PipeValid,
  input  logic [4:0]  PipeReg,
  input  logic [31:0] PipeData,
  output logic        PipeStall,
  input  logic        LongValid,
  output logic        LongReady,
  input  logic [4:0]  LongReg,
  input  logic [31:0] LongData,
  output logic [31:0] Pending,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [4:0]  RdReg1,
  input  logic [4:0]  RdReg2,
  input  logic [31:0] RfData1,
  input  logic [31:0] RfData2,
  output logic [31:0] RdData1,
  output logic [31:0] RdData2
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [4:0]       ent_reg_q  [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             stall_q, stall_d;
  logic             we_q, we_d;
  logic [4:0]       wreg_q, wreg_d;
  logic [31:0]      wdata_q, wdata_d;

  logic pipe_req;
  logic fifo_ne;
  logic accept;
  logic push;
  logic pop;

  assign fifo_ne   = (cnt_q != '0);
  assign LongReady = (cnt_q < CW'(DEPTH));
  assign accept    = LongValid && LongReady;
  // Register 0 completes the handshake but is never stored.
  assign push      = accept && (LongReg != 5'd0);
  assign pipe_req  = !stall_q && PipeValid && (PipeReg != 5'd0);
  assign pop       = !pipe_req && fifo_ne;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    if (push) begin
      wr_ptr_d        = wr_ptr_q + PW'(1);
      vld_d[wr_ptr_q] = 1'b1;
    end
    if (pop) begin
      rd_ptr_d        = rd_ptr_q + PW'(1);
      vld_d[rd_ptr_q] = 1'b0;
    end
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    starve_d = starve_q;
    stall_d  = 1'b0;
    if (pop || !fifo_ne) begin
      starve_d = '0;
    end else if (pipe_req) begin
      if (starve_q == SW'(STARVE_LIMIT - 1)) begin
        starve_d = '0;
        stall_d  = 1'b1;
      end else begin
        starve_d = starve_q + SW'(1);
      end
    end
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      pipe_req: begin
        we_d    = 1'b1;
        wreg_d  = PipeReg;
        wdata_d = PipeData;
      end
      pop: begin
        we_d    = 1'b1;
        wreg_d  = ent_reg_q[rd_ptr_q];
        wdata_d = ent_data_q[rd_ptr_q];
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      vld_q    <= vld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Payload storage needs no reset; vld_q qualifies every entry.
  always_ff @(posedge Clk) begin
    if (push) begin
      ent_reg_q[wr_ptr_q]  <= LongReg;
      ent_data_q[wr_ptr_q] <= LongData;
    end
  end

  always_comb begin
    Pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) Pending[ent_reg_q[i]] = 1'b1;
    end
  end

  assign PipeStall     = stall_q;
  assign RegWrite      = we_q;
  assign WriteRegister = wreg_q;
  assign WriteData     = wdata_q;

`ifdef REGFILE_WB_BYPASS_EN
  assign RdData1 = (we_q && wreg_q == RdReg1 && RdReg1 != 5'd0)
                 ? wdata_q : RfData1;
  assign RdData2 = (we_q && wreg_q == RdReg2 && RdReg2 != 5'd0)
                 ? wdata_q : RfData2;
`else
  assign RdData1 = RfData1;
  assign RdData2 = RfData2;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter.
// Expected values are hand-computed per cycle.
module tb_regfile_write_arbiter;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        PipeValid;
  logic [4:0]  PipeReg;
  logic [31:0] PipeData;
  logic        PipeStall;
  logic        LongValid;
  logic        LongReady;
  logic [4:0]  LongReg;
  logic [31:0] LongData;
  logic [31:0] Pending;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        RegWrite;
  logic [4:0]  RdReg1, RdReg2;
  logic [31:0] RfData1, RfData2;
  logic [31:0] RdData1, RdData2;

  int checks = 0;
  int failures = 0;

  regfile_write_arbiter dut (
    .Clk(Clk), .Rst(Rst),
    .PipeValid(PipeValid), .PipeReg(PipeReg),
    .PipeData(PipeData), .PipeStall(PipeStall),
    .LongValid(LongValid), .LongReady(LongReady),
    .LongReg(LongReg), .LongData(LongData),
    .Pending(Pending),
    .WriteRegister(WriteRegister), .WriteData(WriteData),
    .RegWrite(RegWrite),
    .RdReg1(RdReg1), .RdReg2(RdReg2),
    .RfData1(RfData1), .RfData2(RfData2),
    .RdData1(RdData1), .RdData2(RdData2)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic [31:0] byp_exp;

  initial begin
    Rst = 1'b1;
    PipeValid = 0; PipeReg = 0; PipeData = 0;
    LongValid = 0; LongReg = 0; LongData = 0;
    RdReg1 = 0; RdReg2 = 0; RfData1 = 0; RfData2 = 0;
    tick(); tick();
    chk("rst_we", 32'(RegWrite), 0);
    chk("rst_wr", 32'(WriteRegister), 0);
    chk("rst_wd", WriteData, 0);
    chk("rst_stall", 32'(PipeStall), 0);
    chk("rst_pend", Pending, 0);
    chk("rst_rdy", 32'(LongReady), 1);
    Rst = 1'b0;
    tick();

    // Single pipeline write: one-cycle latency, one-cycle pulse
    PipeValid = 1; PipeReg = 5; PipeData = 32'hDEADBEEF;
    tick();
    chk("p_we", 32'(RegWrite), 1);
    chk("p_wr", 32'(WriteRegister), 5);
    chk("p_wd", WriteData, 32'hDEADBEEF);
    PipeValid = 0;
    tick();
    chk("p_we_off", 32'(RegWrite), 0);
    chk("p_wr_hold", 32'(WriteRegister), 5);

    // Fill FIFO while pipeline writes reg 9 every cycle
    PipeValid = 1; PipeReg = 9; PipeData = 32'h99;
    LongValid = 1;
    for (int i = 1; i <= 4; i++) begin
      LongReg = 5'(i); LongData = 32'h100 + i;
      tick();
    end
    LongValid = 0;
    chk("full_rdy", 32'(LongReady), 0);
    chk("full_pend", Pending, 32'h1E);
    chk("full_wr", 32'(WriteRegister), 9);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_stall", 32'(PipeStall), 0);
    tick();
    chk("stall", 32'(PipeStall), 1);
    chk("stall_rdy", 32'(LongReady), 0);
    // Full FIFO: pop this cycle does not open a slot
    LongValid = 1; LongReg = 6; LongData = 32'h206;
    tick();
    chk("drain_we", 32'(RegWrite), 1);
    chk("drain_wr", 32'(WriteRegister), 1);
    chk("drain_wd", WriteData, 32'h101);
    chk("drain_stall", 32'(PipeStall), 0);
    chk("drain_pend", Pending, 32'h1C);
    chk("drain_rdy", 32'(LongReady), 1);
    tick();
    chk("late_push_pend", Pending, 32'h5C);
    chk("late_push_rdy", 32'(LongReady), 0);
    chk("late_push_wr", 32'(WriteRegister), 9);
    LongValid = 0; PipeValid = 0;
    tick();
    chk("fifo2_wr", 32'(WriteRegister), 2);
    chk("fifo2_wd", WriteData, 32'h102);
    tick();
    chk("fifo3_wr", 32'(WriteRegister), 3);
    tick();
    chk("fifo4_wr", 32'(WriteRegister), 4);
    chk("fifo4_wd", WriteData, 32'h104);
    tick();
    chk("fifo6_wr", 32'(WriteRegister), 6);
    chk("fifo6_wd", WriteData, 32'h206);
    chk("fifo6_pend", Pending, 0);
    tick();
    chk("empty_we", 32'(RegWrite), 0);

    // Register 0 handling on both sources
    PipeValid = 1; PipeReg = 9; PipeData = 32'h99;
    LongValid = 1; LongReg = 7; LongData = 32'h11;
    tick();
    chk("r7_pend", Pending, 32'h80);
    PipeReg = 0; LongReg = 0; LongData = 32'h33;
    tick();
    chk("r0_we", 32'(RegWrite), 1);
    chk("r0_wr", 32'(WriteRegister), 7);
    chk("r0_wd", WriteData, 32'h11);
    chk("r0_pend", Pending, 0);
    chk("r0_rdy", 32'(LongReady), 1);
    PipeValid = 0; LongValid = 0;
    tick();
    chk("r0_noq", 32'(RegWrite), 0);

    // Write-to-read bypass
    PipeValid = 1; PipeReg = 3; PipeData = 32'h55;
    tick();
    PipeValid = 0;
    RdReg1 = 3; RfData1 = 0; RdReg2 = 0; RfData2 = 32'hAA;
    #1;
`ifdef REGFILE_WB_BYPASS_EN
    byp_exp = 32'h55;
`else
    byp_exp = 32'h0;
`endif
    chk("byp_rd1", RdData1, byp_exp);
    chk("byp_rd2", RdData2, 32'hAA);
    tick();
    chk("byp_idle", RdData1, 0);

    // Asynchronous reset with three entries queued
    PipeValid = 1; PipeReg = 9; PipeData = 32'h99;
    LongValid = 1;
    for (int i = 10; i <= 12; i++) begin
      LongReg = 5'(i); LongData = 32'h300 + i;
      tick();
    end
    LongValid = 0;
    chk("mid_pend", Pending, 32'h1C00);
    chk("mid_we", 32'(RegWrite), 1);
    #2 Rst = 1'b1;
    #1;
    chk("arst_we", 32'(RegWrite), 0);
    chk("arst_pend", Pending, 0);
    chk("arst_rdy", 32'(LongReady), 1);
    PipeValid = 0;
    tick(); tick();
    Rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_rst_we", 32'(RegWrite), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
